// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the multirate FIR filterbank datapath.
//   FIR_ACC_W / FIR_OUT_W / FIR_SHIFT : default accumulator width, output
//                                       sample width, fractional bits removed
//   OUT_MAX / OUT_MIN                 : output sample saturation limits
//   acc_t / sample_t                  : signed accumulator / output sample
//   quant_t, quantize()               : round + saturate an accumulator value
//                                       to a sample, also reporting clamping
// Build option: FIR_QUANT_CONVERGENT_ROUND_EN selects round-half-to-even;
// otherwise quantize() rounds half up.
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int FIR_ACC_W = 28;
   localparam int FIR_OUT_W = 16;
   localparam int FIR_SHIFT = 6;

   typedef logic signed [FIR_ACC_W-1:0] acc_t;
   typedef logic signed [FIR_OUT_W-1:0] sample_t;

   localparam sample_t OUT_MAX = sample_t'((2 ** (FIR_OUT_W - 1)) - 1);
   localparam sample_t OUT_MIN = sample_t'(-(2 ** (FIR_OUT_W - 1)));

   // Rounding and limit constants held at ACC_W+1 bits so the rounding add
   // can never wrap.
   localparam logic signed [FIR_ACC_W:0] RND_HALF = (FIR_ACC_W + 1)'(2 ** (FIR_SHIFT - 1));
   localparam logic signed [FIR_ACC_W:0] R_MAX    = (FIR_ACC_W + 1)'((2 ** (FIR_OUT_W - 1)) - 1);
   localparam logic signed [FIR_ACC_W:0] R_MIN    = (FIR_ACC_W + 1)'(-(2 ** (FIR_OUT_W - 1)));
   localparam logic signed [FIR_ACC_W:0] R_ONE    = (FIR_ACC_W + 1)'(1);
`ifdef FIR_QUANT_CONVERGENT_ROUND_EN
   localparam logic [FIR_SHIFT-1:0] RND_TIE = FIR_SHIFT'(1) << (FIR_SHIFT - 1);
`endif

   typedef struct packed {
      sample_t value;
      logic    sat;
   } quant_t;

   function automatic quant_t quantize(input acc_t x);
      logic signed [FIR_ACC_W:0] wide;
      logic signed [FIR_ACC_W:0] r;
      quant_t q;
      wide = {x[FIR_ACC_W-1], x} + RND_HALF;
      r    = wide >>> FIR_SHIFT;
`ifdef FIR_QUANT_CONVERGENT_ROUND_EN
      // Exact tie: half-up landed on the upper neighbour; step back if odd.
      if ((x[FIR_SHIFT-1:0] == RND_TIE) && r[0]) begin
         r = r - R_ONE;
      end
`endif
      if (r > R_MAX) begin
         q.value = OUT_MAX;
         q.sat   = 1'b1;
      end else if (r < R_MIN) begin
         q.value = OUT_MIN;
         q.sat   = 1'b1;
      end else begin
         q.value = r[FIR_OUT_W-1:0];
         q.sat   = 1'b0;
      end
      return q;
   endfunction

endpackage

// File: rtl/fir_decim_quantizer_if.sv
// -----------------------------------------------------------------------------
// fir_decim_quantizer_if
// Stream bundle around the decimating quantizer.
//   in_data/in_valid/in_ready    : accumulator samples into the block
//   out_data/out_valid/out_ready : quantized samples out of the block
// Modports: master = upstream/downstream side (bench or neighbours),
//           slave  = the quantizer itself.
// -----------------------------------------------------------------------------
interface fir_decim_quantizer_if
   import fir_pkg::*;
#(
   parameter int ACC_W = FIR_ACC_W,
   parameter int OUT_W = FIR_OUT_W
);
   logic signed [ACC_W-1:0] in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/fir_skid_fifo2.sv
// -----------------------------------------------------------------------------
// fir_skid_fifo2
// Two-entry first-word-fall-through FIFO built as head/tail registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write (caller never pushes while count==2 without a pop)
//   pop        : read, ignored while empty
//   dout       : head entry; holds its last value while empty
//   valid      : count != 0
//   count      : occupancy 0..2
// -----------------------------------------------------------------------------
module fir_skid_fifo2 #(
   parameter int W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic signed [W-1:0] din,
   input  logic                pop,
   output logic signed [W-1:0] dout,
   output logic                valid,
   output logic [1:0]          count
);
   logic signed [W-1:0] head_q;
   logic signed [W-1:0] tail_q;
   logic [1:0]          cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         case (cnt_q)
            2'd0: begin
               if (push) begin
                  head_q <= din;
                  cnt_q  <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head_q <= din;
               end else if (push) begin
                  tail_q <= din;
                  cnt_q  <= 2'd2;
               end else if (pop) begin
                  cnt_q  <= 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  head_q <= tail_q;
                  if (push) begin
                     tail_q <= din;
                  end else begin
                     cnt_q  <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

   assign dout  = head_q;
   assign valid = (cnt_q != 2'd0);
   assign count = cnt_q;
endmodule

// File: rtl/fir_decim_quantizer.sv
// -----------------------------------------------------------------------------
// fir_decim_quantizer
// Keeps every DECIM-th accumulator sample from the FIR core, rounds it down by
// SHIFT fractional bits, saturates to OUT_W and emits it through a two-entry
// valid/ready buffer (latency 1 from accept to out_valid).
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   strm (slave)     : in_data/in_valid/in_ready, out_data/out_valid/out_ready
//   phase_clr        : return the decimation phase to 0 after this cycle
//   sat_flag         : sticky, set when a kept sample was clamped
//   sat_clr          : clears sat_flag (a coincident set wins)
// Build option: FIR_QUANT_CONVERGENT_ROUND_EN (round half to even).
// ACC_W/OUT_W/SHIFT must match the fir_pkg defaults used by quantize().
// -----------------------------------------------------------------------------
module fir_decim_quantizer
   import fir_pkg::*;
#(
   parameter int ACC_W = FIR_ACC_W,
   parameter int OUT_W = FIR_OUT_W,
   parameter int SHIFT = FIR_SHIFT,
   parameter int DECIM = 4
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   fir_decim_quantizer_if.slave  strm,
   input  logic                  phase_clr,
   input  logic                  sat_clr,
   output logic                  sat_flag
);
   if (ACC_W != FIR_ACC_W || OUT_W != FIR_OUT_W || SHIFT != FIR_SHIFT) begin : g_width_check
      $error("fir_decim_quantizer: ACC_W/OUT_W/SHIFT must equal the fir_pkg values");
   end
   if (DECIM < 1 || SHIFT < 1) begin : g_range_check
      $error("fir_decim_quantizer: DECIM and SHIFT must be at least 1");
   end

   localparam int              PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

   logic [PH_W-1:0] phase_q;
   logic            in_ready_q;
   logic            sat_flag_q;
   logic            accept_p0;
   logic            keep_p0;
   quant_t          quant_p0;
   logic            pop_p1;
   logic [1:0]      count_p1;
   logic [1:0]      count_next;
   sample_t         data_p1;
   logic            valid_p1;

   // ---- p0: accept, phase decision, quantize ----
   assign accept_p0 = strm.in_valid && in_ready_q;
   assign keep_p0   = accept_p0 && (phase_q == '0);
   assign quant_p0  = quantize(strm.in_data);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         phase_q <= '0;
      end else if (phase_clr) begin
         phase_q <= '0;
      end else if (accept_p0) begin
         phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         sat_flag_q <= 1'b0;
      end else if (keep_p0 && quant_p0.sat) begin
         sat_flag_q <= 1'b1;
      end else if (sat_clr) begin
         sat_flag_q <= 1'b0;
      end
   end

   // ---- p1: output buffer ----
   assign pop_p1     = valid_p1 && strm.out_ready;
   assign count_next = count_p1 + {1'b0, keep_p0} - {1'b0, pop_p1};

   // in_ready looks at next-cycle occupancy so it never depends on out_ready
   // combinationally.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         in_ready_q <= 1'b0;
      end else begin
         in_ready_q <= (count_next != 2'd2);
      end
   end

   fir_skid_fifo2 #(
      .W (OUT_W)
   ) u_fifo (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .push  (keep_p0),
      .din   (quant_p0.value),
      .pop   (pop_p1),
      .dout  (data_p1),
      .valid (valid_p1),
      .count (count_p1)
   );

   assign strm.in_ready  = in_ready_q;
   assign strm.out_data  = data_p1;
   assign strm.out_valid = valid_p1;
   assign sat_flag       = sat_flag_q;
endmodule

// File: tb/tb_fir_decim_quantizer.sv
module tb_fir_decim_quantizer;
   import fir_pkg::*;

`ifdef FIR_QUANT_CONVERGENT_ROUND_EN
   localparam int EXP_M96 = -2;
   localparam int EXP_160 = 2;
`else
   localparam int EXP_M96 = -1;
   localparam int EXP_160 = 3;
`endif

   logic ap_clk    = 1'b0;
   logic ap_rst_n  = 1'b0;
   logic phase_clr = 1'b0;
   logic sat_clr   = 1'b0;
   logic sat_flag;
   int   n_assert  = 0;
   int   n_fail    = 0;

   fir_decim_quantizer_if #(.ACC_W(FIR_ACC_W), .OUT_W(FIR_OUT_W)) bus ();

   fir_decim_quantizer #(.DECIM(4)) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .strm      (bus),
      .phase_clr (phase_clr),
      .sat_clr   (sat_clr),
      .sat_flag  (sat_flag)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Offer one sample and wait (bounded) for the accept edge.
   task automatic send(input int v, input string tag);
      logic acc;
      acc          = 1'b0;
      bus.in_data  = acc_t'(v);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20 && !acc; i++) begin
         if (bus.in_ready) acc = 1'b1;
         step();
      end
      bus.in_valid = 1'b0;
      chk({tag, "_acc"}, acc, 1);
   endtask

   task automatic clr_phase();
      phase_clr = 1'b1;
      step();
      phase_clr = 1'b0;
   endtask

   task automatic chk_out(input string tag, input int v);
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_data"}, bus.out_data, v);
   endtask

   initial begin
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      step();
      step();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_sat_flag", sat_flag, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      ap_rst_n = 1'b1;

      // Rounding
      send(100, "rnd100");
      chk_out("rnd100", 2);
      clr_phase();
      chk("rnd_empty_valid", bus.out_valid, 0);
      chk("rnd_empty_hold", bus.out_data, 2);
      send(-96, "rndm96");
      chk_out("rndm96", EXP_M96);
      clr_phase();
      send(96, "rnd96");
      chk_out("rnd96", 2);
      clr_phase();

      // Decimation, continuous stream
      for (int i = 0; i < 12; i++) begin
         send(64 * i, "dec");
         chk("dec_valid", bus.out_valid, (i % 4 == 0) ? 1 : 0);
         if (i % 4 == 0) chk("dec_data", bus.out_data, i);
      end

      // Decimation with phase_clr on the third accept
      for (int k = 0; k < 8; k++) begin
         phase_clr = (k == 2);
         send(64 * k, "pclr");
         phase_clr = 1'b0;
         chk("pclr_valid", bus.out_valid, (k == 0 || k == 3 || k == 7) ? 1 : 0);
         if (k == 0 || k == 3 || k == 7) chk("pclr_data", bus.out_data, k);
      end
      clr_phase();

      // Saturation
      send(4194304, "satp");
      chk_out("satp", 32767);
      chk("satp_flag", sat_flag, 1);
      clr_phase();
      send(-8388608, "satn");
      chk_out("satn", -32768);
      chk("satn_flag", sat_flag, 1);
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      chk("satclr_flag", sat_flag, 0);
      clr_phase();
      send(2097088, "edge_hi");
      chk_out("edge_hi", 32767);
      chk("edge_hi_flag", sat_flag, 0);
      clr_phase();
      send(-2097184, "edge_lo");
      chk_out("edge_lo", -32768);
      chk("edge_lo_flag", sat_flag, 0);
      clr_phase();
      send(2097120, "over_hi");
      chk_out("over_hi", 32767);
      chk("over_hi_flag", sat_flag, 1);
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      chk("satclr2_flag", sat_flag, 0);
      clr_phase();
      sat_clr = 1'b1;
      send(4194304, "satcoin");
      sat_clr = 1'b0;
      chk_out("satcoin", 32767);
      chk("satcoin_flag", sat_flag, 1);
      clr_phase();

      // Rounding ties
      send(160, "tie160");
      chk_out("tie160", EXP_160);
      clr_phase();
      send(96, "tie96");
      chk_out("tie96", 2);
      clr_phase();
      send(224, "tie224");
      chk_out("tie224", 4);
      clr_phase();

      // Backpressure (phase_clr held so every sample is kept)
      bus.out_ready = 1'b0;
      phase_clr     = 1'b1;
      send(640, "bp1");
      chk_out("bp1", 10);
      chk("bp1_in_ready", bus.in_ready, 1);
      send(1280, "bp2");
      chk_out("bp2_head", 10);
      chk("bp2_in_ready", bus.in_ready, 0);
      bus.in_data  = acc_t'(1920);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_stall_in_ready", bus.in_ready, 0);
         chk_out("bp_stall_hold", 10);
      end
      bus.out_ready = 1'b1;
      step();
      chk_out("bp_rel1", 20);
      chk("bp_rel1_in_ready", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      chk_out("bp_rel2", 30);
      step();
      chk("bp_drained_valid", bus.out_valid, 0);
      chk("bp_drained_hold", bus.out_data, 30);
      phase_clr = 1'b0;

      // Reset mid-stream with the buffer full and phase at 1
      bus.out_ready = 1'b0;
      phase_clr     = 1'b1;
      send(4194304, "rs1");
      phase_clr = 1'b0;
      send(64, "rs2");
      chk("rs_full_in_ready", bus.in_ready, 0);
      chk("rs_full_sat", sat_flag, 1);
      chk_out("rs_full", 32767);
      #2;
      ap_rst_n = 1'b0;
      #1;
      chk("rs_async_valid", bus.out_valid, 0);
      chk("rs_async_in_ready", bus.in_ready, 0);
      chk("rs_async_sat", sat_flag, 0);
      chk("rs_async_data", bus.out_data, 0);
      step();
      step();
      ap_rst_n      = 1'b1;
      bus.out_ready = 1'b1;
      send(320, "rs_first");
      chk_out("rs_first", 5);
      step();
      chk("rs_final_valid", bus.out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
